// File: rtl/bin2bcd_led_feeder.sv
// Sequential double-dabble converter: 32-bit binary in, 8 packed BCD digits out as a
// single-cycle write into the 7-segment display data register.
module bin2bcd_led_feeder #(
  parameter logic [31:0] LED_ADDR    = 32'h0000_0000,
  parameter logic [31:0] OVF_PATTERN = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [31:0] led_addr,
  output logic        led_wen,
  output logic [31:0] led_wdata,
  output logic        busy,
  output logic        ovf
);

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StOut
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ovf_q, ovf_d;

  logic        accept;
  logic [39:0] bcd_adj;
  logic [39:0] bcd_shift;
  logic [31:0] bin_shift;
  logic        ovf_now;

  assign accept = in_valid && (state_q == StIdle);

  // Add-3 on each digit >= 5; a digit tops out at 12 so nothing carries into its neighbour.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 10; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  assign bcd_shift = {bcd_adj[38:0], bin_q[31]};
  assign bin_shift = {bin_q[30:0], 1'b0};
  assign ovf_now   = |bcd_shift[39:32];

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    wen_d   = 1'b0;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StConv;
          bin_d   = in_data;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StConv: begin
        bin_d = bin_shift;
        bcd_d = bcd_shift;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = StOut;
          wen_d   = 1'b1;
          ovf_d   = ovf_now;
          wdata_d = ovf_now ? OVF_PATTERN : bcd_shift[31:0];
        end
      end
      StOut: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q == StConv) || (state_q == StOut);
  assign led_addr  = LED_ADDR;
  assign led_wen   = wen_q;
  assign led_wdata = wdata_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_led_feeder.sv
// Self-checking bench for bin2bcd_led_feeder: directed scenarios plus randomized values
// against a decimal-digit reference model.
module tb_bin2bcd_led_feeder;

  localparam logic [31:0] TB_ADDR = 32'h4000_0020;
  localparam logic [31:0] TB_OVF  = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [31:0] led_addr;
  logic        led_wen;
  logic [31:0] led_wdata;
  logic        busy;
  logic        ovf;

  int n_cmp;
  int n_bad;

  bin2bcd_led_feeder #(
    .LED_ADDR   (TB_ADDR),
    .OVF_PATTERN(TB_OVF)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .led_addr (led_addr),
    .led_wen  (led_wen),
    .led_wdata(led_wdata),
    .busy     (busy),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal digits by repeated division; anything above eight digits shows the overflow pattern.
  function automatic logic [31:0] ref_bcd(input logic [31:0] v);
    logic [31:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    if (v > 32'd99_999_999) return TB_OVF;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Accept v, then watch 33 edges. lat is the edge index (relative to the accept) of the
  // first led_wen, or -1 if none; in_data is scrambled right after accept.
  task automatic run_one(input logic [31:0] v, output logic [31:0] wd, output logic ov_after,
                         output int lat, output int pulses, output logic addr_ok);
    int w;
    w = 0;
    wd = '0;
    addr_ok = 1'b0;
    pulses = 0;
    lat = -1;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      ov_after = 1'bx;
      return;
    end
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      if (led_wen) begin
        pulses++;
        if (lat < 0) lat = k;
        wd = led_wdata;
        addr_ok = (led_addr == TB_ADDR);
      end
    end
    ov_after = ovf;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    #12;
    n_cmp++;
    if ({led_wen, led_wdata, ovf, busy, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: wen/wdata/ovf/busy/ready got %b/%h/%b/%b/%b want 0/0/0/0/1",
               led_wen, led_wdata, ovf, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] wd;
    logic ov, aok;
    int lat, p;
    run_one(32'd12345678, wd, ov, lat, p, aok);
    n_cmp++;
    if (p !== 1 || lat !== 32) begin
      n_bad++;
      $display("FAIL basic_timing: pulses=%0d at edge %0d, want 1 at edge 32", p, lat);
    end
    n_cmp++;
    if (wd !== 32'h1234_5678 || ov !== 1'b0 || aok !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_data: wdata=%h ovf=%b addr_ok=%b, want 12345678/0/1", wd, ov, aok);
    end
  endtask

  task automatic test_boundaries;
    logic [31:0] vals[4];
    logic [31:0] wd;
    logic ov, aok;
    int lat, p;
    vals = '{32'd0, 32'd99_999_999, 32'd9, 32'd10};
    foreach (vals[i]) begin
      run_one(vals[i], wd, ov, lat, p, aok);
      n_cmp++;
      if (wd !== ref_bcd(vals[i]) || ov !== 1'b0 || p !== 1 || lat !== 32) begin
        n_bad++;
        $display("FAIL boundary_%0d: wdata=%h ovf=%b pulses=%0d lat=%0d, want %h/0/1/32",
                 vals[i], wd, ov, p, lat, ref_bcd(vals[i]));
      end
    end
  endtask

  task automatic test_overflow;
    logic [31:0] wd;
    logic ov, aok;
    int lat, p;
    run_one(32'd100_000_000, wd, ov, lat, p, aok);
    n_cmp++;
    if (wd !== TB_OVF || ov !== 1'b1 || lat !== 32) begin
      n_bad++;
      $display("FAIL ovf_1e8: wdata=%h ovf=%b lat=%0d, want %h/1/32", wd, ov, lat, TB_OVF);
    end
    run_one(32'hFFFF_FFFF, wd, ov, lat, p, aok);
    n_cmp++;
    if (wd !== TB_OVF || ov !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_max: wdata=%h ovf=%b, want %h/1", wd, ov, TB_OVF);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (ovf !== 1'b1 || led_wdata !== TB_OVF) begin
      n_bad++;
      $display("FAIL ovf_sticky: ovf=%b wdata=%h, want 1/%h", ovf, led_wdata, TB_OVF);
    end
    run_one(32'd7, wd, ov, lat, p, aok);
    n_cmp++;
    if (wd !== 32'h0000_0007 || ov !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: wdata=%h ovf=%b, want 00000007/0", wd, ov);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals[3];
    int          edges[$];
    logic [31:0] datas[$];
    int          phase, idx;
    vals = '{32'd5, 32'd42, 32'd1000};
    for (int t = 0; t < 110; t++) begin
      @(negedge clk);
      phase = t % 34;
      idx   = t / 34;
      if (phase == 0) begin
        if (idx < 3) begin
          in_valid = 1'b1;
          in_data  = vals[idx];
        end else begin
          in_valid = 1'b0;
        end
      end else if (phase == 5) begin
        in_data = $urandom;
      end
      @(posedge clk);
      #1;
      if (led_wen) begin
        edges.push_back(t);
        datas.push_back(led_wdata);
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (edges.size() != 3) begin
      n_bad++;
      $display("FAIL b2b_count: pulses=%0d, want 3", edges.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (edges[i] != 32 + 34 * i || datas[i] !== ref_bcd(vals[i])) begin
          n_bad++;
          $display("FAIL b2b_%0d: edge=%0d data=%h, want edge=%0d data=%h",
                   i, edges[i], datas[i], 32 + 34 * i, ref_bcd(vals[i]));
        end
      end
    end
  endtask

  task automatic test_abort;
    logic [31:0] wd;
    logic ov, aok;
    int lat, p, seen;
    // Reset mid-CONV: no write may follow.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'd4321;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({led_wen, led_wdata, busy, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL abort_async: wen/wdata/busy/ready got %b/%h/%b/%b want 0/0/0/1",
               led_wen, led_wdata, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (led_wen) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL abort_no_write: pulses=%0d, want 0", seen);
    end
    // Reset while led_wen is high: strobe must drop without a clock edge.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'd88;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    n_cmp++;
    if (led_wen !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_out_setup: wen=%b, want 1", led_wen);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (led_wen !== 1'b0 || led_wdata !== 32'h0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_out: wen=%b wdata=%h busy=%b, want 0/0/0", led_wen, led_wdata, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_one(32'd31415926, wd, ov, lat, p, aok);
    n_cmp++;
    if (wd !== 32'h3141_5926 || lat !== 32 || p !== 1) begin
      n_bad++;
      $display("FAIL abort_recover: wdata=%h lat=%0d pulses=%0d, want 31415926/32/1", wd, lat, p);
    end
  endtask

  task automatic test_random;
    logic [31:0] v, wd, exp;
    logic ov, aok, exp_ov;
    int lat, p;
    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = $urandom_range(0, 99_999_999);
        2: v = $urandom_range(99_999_990, 100_000_010);
        default: v = $urandom_range(0, 9999);
      endcase
      exp    = ref_bcd(v);
      exp_ov = (v > 32'd99_999_999);
      run_one(v, wd, ov, lat, p, aok);
      n_cmp++;
      if (wd !== exp || ov !== exp_ov || lat !== 32 || p !== 1 || aok !== 1'b1) begin
        n_bad++;
        $display("FAIL random_%0d: in=%0d wdata=%h ovf=%b lat=%0d pulses=%0d addr_ok=%b, want %h/%b/32/1/1",
                 n, v, wd, ov, lat, p, aok, exp, exp_ov);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset;
    test_basic;
    test_boundaries;
    test_overflow;
    test_back_to_back;
    test_abort;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
